// File: rtl/parameterized_mux.sv
// Registered fixed-priority request/grant multiplexer: the lowest-index active
// request wins; with no request the DEFAULT_SEL channel is forwarded, ungranted.
module parameterized_mux #(
  parameter int width       = 4,
  parameter int n           = 4,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [n*width-1:0]   in,
  input  logic [n-1:0]         req,
  output logic [n-1:0]         grant,
  output logic [width-1:0]     out
);

  if (width < 1) begin : g_bad_width
    $error("parameterized_mux: width must be >= 1");
  end
  if (n < 1) begin : g_bad_n
    $error("parameterized_mux: n must be >= 1");
  end
  if (DEFAULT_SEL < 0 || DEFAULT_SEL >= n) begin : g_bad_default
    $error("parameterized_mux: DEFAULT_SEL must be in 0..n-1");
  end

  localparam logic [n-1:0] DEFAULT_ONEHOT = (n)'(1) << DEFAULT_SEL;

  function automatic logic [n-1:0] first_set(input logic [n-1:0] r);
    logic [n-1:0] g;
    logic         found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (r[i] && !found) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // AND-OR selection keeps unknowns on deselected channels out of the result.
  function automatic logic [width-1:0] select_data(input logic [n*width-1:0] d,
                                                   input logic [n-1:0]       sel);
    logic [width-1:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      acc = acc | (d[i*width +: width] & {width{sel[i]}});
    end
    return acc;
  endfunction

  logic [n-1:0]     grant_p0;
  logic [n-1:0]     sel_p0;
  logic [width-1:0] out_p0;

  // Stage 0: priority decode and data select from the current sample.
  always_comb begin
    grant_p0 = first_set(req);
    sel_p0   = (req == '0) ? DEFAULT_ONEHOT : grant_p0;
    out_p0   = select_data(in, sel_p0);
  end

  // Stage 1: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      out   <= '0;
    end else begin
      grant <= grant_p0;
      out   <= out_p0;
    end
  end

endmodule

// File: tb/tb_parameterized_mux.sv
// Scoreboard bench for parameterized_mux: default-select 0, default-select 2
// and single-channel instances all share one stimulus stream.
module tb_parameterized_mux;
  localparam int W = 4;
  localparam int N = 4;
  localparam logic [N*W-1:0] IN_PLAN = 16'hABCD;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in;
  logic [N-1:0]   req;
  logic [N-1:0]   grant0, grant2;
  logic [W-1:0]   out0, out2, out1;
  logic [0:0]     grant1;

  parameterized_mux #(.width(W), .n(N), .DEFAULT_SEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in), .req(req), .grant(grant0), .out(out0));
  parameterized_mux #(.width(W), .n(N), .DEFAULT_SEL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in), .req(req), .grant(grant2), .out(out2));
  parameterized_mux #(.width(W), .n(1), .DEFAULT_SEL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in[W-1:0]), .req(req[0:0]), .grant(grant1), .out(out1));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] o0;
    logic [W-1:0] o2;
    logic         g1;
    logic [W-1:0] o1;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: winner is the lowest set request bit; idle forwards the default channel.
  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] r);
    return r & (~r + 1'b1);
  endfunction

  function automatic logic [W-1:0] ref_out(input logic [N-1:0] r, input logic [N*W-1:0] d,
                                           input int dflt);
    logic [W-1:0] ch [N];
    int           w;
    for (int i = 0; i < N; i++) ch[i] = d[i*W +: W];
    w = dflt;
    for (int i = N - 1; i >= 0; i--) if (r[i]) w = i;
    return ch[w];
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input bit rel = 1'b0);
    exp_t x;
    @(negedge clk);
    if (rel) begin
      rst_n  = 1'b1;
      mon_en = 1'b1;
    end
    req = r;
    in  = d;
    if (mon_en) begin
      x.g  = ref_grant(r);
      x.o0 = ref_out(r, d, 0);
      x.o2 = ref_out(r, d, 2);
      x.g1 = r[0];
      x.o1 = d[W-1:0];
      sb.push_back(x);
    end
  endtask

  task automatic dcheck(input string name, input logic [N-1:0] g, input logic [W-1:0] o0,
                        input logic [W-1:0] o2);
    @(posedge clk);
    #2;
    check({name, "_grant"}, grant0, g);
    check({name, "_out"}, out0, o0);
    check({name, "_out_dflt2"}, out2, o2);
  endtask

  task automatic check_zero(input string name);
    check({name, "_grant0"}, grant0, 0);
    check({name, "_out0"}, out0, 0);
    check({name, "_grant2"}, grant2, 0);
    check({name, "_out2"}, out2, 0);
    check({name, "_grant1"}, grant1, 0);
    check({name, "_out1"}, out1, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_grant", grant0, e.g);
      check("sb_grant_dflt2", grant2, e.g);
      check("sb_out", out0, e.o0);
      check("sb_out_dflt2", out2, e.o2);
      check("sb_grant_n1", grant1, e.g1);
      check("sb_out_n1", out1, e.o1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    in    = IN_PLAN;
    #1 rst_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_hold");

    step(4'b0010, IN_PLAN, 1'b1);
    dcheck("single_ch1", 4'b0010, 4'hC, 4'hC);
    step(4'b0100, IN_PLAN);
    dcheck("single_ch2", 4'b0100, 4'hB, 4'hB);
    step(4'b1001, IN_PLAN);
    dcheck("prio_1001", 4'b0001, 4'hD, 4'hD);
    step(4'b1111, IN_PLAN);
    dcheck("prio_1111", 4'b0001, 4'hD, 4'hD);
    step(4'b1000, IN_PLAN);
    dcheck("prio_1000", 4'b1000, 4'hA, 4'hA);
    step(4'b0000, IN_PLAN);
    dcheck("default", 4'b0000, 4'hD, 4'hB);

    step(4'b0010, IN_PLAN);
    step(4'b0100, IN_PLAN);
    #1;
    check("hold_grant", grant0, 4'b0010);
    check("hold_out", out0, 4'hC);
    dcheck("hold_update", 4'b0100, 4'hB, 4'hB);

    step(4'b0100, IN_PLAN);
    dcheck("pre_reset", 4'b0100, 4'hB, 4'hB);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1 check_zero("midop_reset");
    @(posedge clk);
    #1 check_zero("midop_reset_edge");
    step(4'b0100, IN_PLAN, 1'b1);
    dcheck("reset_release", 4'b0100, 4'hB, 4'hB);

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), 16'($urandom));
    end

    repeat (2) @(posedge clk);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parameterized_mux.md
# parameterized_mux

Registered, fixed-priority request/grant multiplexer with a default select. Each cycle it samples `n` request lines and grants the highest-priority active one. It drives that requester's `width`-bit data word to `out`. With no request active, it forwards the data of a parameterized default channel and asserts no grant. It sits between multiple data sources and a single-consumer datapath.

## Interface
- `width`, default 4: bits per data channel; must be ≥1.
- `n`, default 4: number of channels/requesters; must be ≥1.
- `DEFAULT_SEL`, default 0: channel forwarded when no request is active; must be in 0..n-1.
- Parameter order is `width`, `n`, `DEFAULT_SEL`, so positional override `#(width, n)` is legal.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `in` input `n*width`: packed data; channel i occupies bits `[i*width +: width]`, so channel 0 is the LSB slice.
- `req` input `n`: request vector; bit i requests channel i.
- `grant` output `n`: one-hot grant (registered); all-zero when idle.
- `out` output `width`: selected channel data (registered).

## Operation
- Priority is fixed; the lowest index wins. Winner w = index of the least-significant set bit of `req`.
- Any req ≠ 0: next `grant` = one-hot bit w (at most one bit set); next `out` = `in[w*width +: width]`.
- req == 0: next `grant` = 0; next `out` = `in[DEFAULT_SEL*width +: width]`.
- No state other than the two output registers. Priority does not depend on past grants (no round-robin, no lock).
- `in` and `req` are sampled in the same cycle. Data and grant always correspond to the same sample.
- X/Z on unselected channels must not propagate to `out`.
- n == 1: grant = req, and `out` = channel 0 regardless of request.

## Timing
- Latency is 1 cycle: `req`/`in` sampled at rising edge k appear on `grant`/`out` after edge k and hold until edge k+1.
- No handshake. A requester is granted in every cycle it is the highest active request. Dropping `req` removes the grant on the next edge.
- Reset: while `rst_n` = 0, `grant` = 0 and `out` = 0 immediately, independent of `clk`. Reset overrides an in-flight sample.
- Reset release: the first rising edge with `rst_n` = 1 loads the normal function of the sampled inputs. No extra dead cycles.
- Reset asserted mid-operation clears both outputs asynchronously. The values held before reset are not restored.
- Input changes between edges have no effect on outputs.

## Test plan
All cases use width=4, n=4, DEFAULT_SEL=0, in = {4'hA,4'hB,4'hC,4'hD} (channel0=D, 1=C, 2=B, 3=A). Check one cycle after each applied input.
- Reset: assert `rst_n`=0 with req=4'b1111 -> grant=4'b0000, out=4'h0 without any clock edge.
- Single request: req=4'b0010 -> grant=4'b0010, out=4'hC; req=4'b0100 -> grant=4'b0100, out=4'hB.
- Priority: req=4'b1001 -> grant=4'b0001, out=4'hD; req=4'b1111 -> grant=4'b0001, out=4'hD; req=4'b1000 -> grant=4'b1000, out=4'hA.
- Default select: req=4'b0000 -> grant=4'b0000, out=4'hD. Repeat with DEFAULT_SEL=2 -> out=4'hB.
- Latency/hold: change req from 4'b0010 to 4'b0100 mid-cycle -> outputs stay grant=4'b0010, out=4'hC until the next rising edge, then update. Randomized req/in must match a 1-cycle-delayed reference model.
- Mid-operation reset: with grant=4'b0100 active, pulse `rst_n` low between edges -> outputs go to 0 at once. The first edge after release with req=4'b0100 restores grant=4'b0100, out=4'hB.
